// File: rtl/arb2_stream_if.sv
// Stream bundle between two upstream channels, the arbiter and one downstream consumer.
interface arb2_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in0_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;

    // Arbiter side: sinks both input streams, sources the merged stream.
    modport master (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, sel, out_data, out_src, out_valid
    );

    // Environment side: sources the input streams, sinks the merged stream.
    modport slave (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, sel, out_data, out_src, out_valid
    );
endinterface

// File: rtl/arb2_stream.sv
// Two-input round-robin stream arbiter with burst grant and a registered output beat.
module arb2_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    arb2_stream_if.master bus
);
    localparam int unsigned CW    = $clog2(BURST) + 1;
    localparam bit          MULTI = (BURST > 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic             out_valid_q;
    logic             out_src_q;
    logic [WIDTH-1:0] out_data_q;

    logic             sel_c;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             load_en;
    logic             grant_ok;
    logic             acc;

    // Select, per-channel ready and accept decode for the current cycle.
    always_comb begin
        sel_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in0_valid || bus.in1_valid)
                    sel_c = bus.in1_valid && !(bus.in0_valid && last);
                else
                    sel_c = !last;
            end
            GRANT0:  sel_c = 1'b0;
            GRANT1:  sel_c = 1'b1;
            default: sel_c = 1'b0;
        endcase
        sel_valid = sel_c ? bus.in1_valid : bus.in0_valid;
        sel_data  = sel_c ? bus.in1_data  : bus.in0_data;
        load_en   = !out_valid_q || bus.out_ready;
        // In IDLE a ready is only offered to a channel that is actually requesting.
        grant_ok  = !reset && load_en && ((state != IDLE) || sel_valid);
        acc       = grant_ok && sel_valid;
        cnt_inc   = cnt + CW'(1);
    end

    assign bus.sel       = sel_c;
    assign bus.in0_ready = grant_ok && !sel_c;
    assign bus.in1_ready = grant_ok && sel_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_data  = out_data_q;

    // Arbitration state, burst counter and output beat register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (acc) begin
                out_data_q  <= sel_data;
                out_src_q   <= sel_c;
                out_valid_q <= 1'b1;
                last        <= sel_c;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (acc && MULTI) begin
                        state <= sel_c ? GRANT1 : GRANT0;
                        cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (acc) begin
                        if (cnt_inc == CW'(BURST)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (!sel_valid) begin
                        // Granted channel went quiet: release so the other side can win next cycle.
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end
endmodule
